// File: rtl/cpu_pkg.sv
// ============================================================================
// Package  : cpu_pkg
// Brief    : Shared CPU datapath widths, control-bundle type and forwarding source encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 6;
  localparam int CPU_CTRL_W = 16;
  localparam int CPU_CNT_W  = 32;

  typedef logic [CPU_CTRL_W-1:0] ctrl_t;

  typedef enum logic [1:0] {
    SRC_FILE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MEM  = 2'd2
  } fwdSrc_e;

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ============================================================================
// Module   : fwd_mux
// Brief    : Per-operand priority select of the newest value: EX/MEM result, then WB, then file.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [DATA_W-1:0] fileData,
  input  logic              memValid,
  input  logic              memWrEn,
  input  logic [ADDR_W-1:0] memRd,
  input  logic [DATA_W-1:0] memData,
  input  logic              wbWrEn,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0] wbData,
  output logic [DATA_W-1:0] selData
);

  fwdSrc_e w_src;

  // The WB path matters because the file returns the old value on a same-cycle write/read.
  always_comb begin
    w_src = SRC_FILE;
    if (memValid && memWrEn && (memRd == srcAddr)) begin
      w_src = SRC_MEM;
    end else if (wbWrEn && (wbAddr == srcAddr)) begin
      w_src = SRC_WB;
    end
  end

  always_comb begin
    selData = fileData;
    case (w_src)
      SRC_MEM: selData = memData;
      SRC_WB:  selData = wbData;
      default: selData = fileData;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// ============================================================================
// Module   : operand_fetch_stage
// Brief    : ID->EX operand fetch: forwarding, hazard stall, valid/ready ID/EX register.
//            Option macro OPFETCH_BYPASS_EN: mem/wb forwarding with load-use-only stall;
//            without it operands come from the file and any in-flight write stalls.
// Revision : 1.0
// ============================================================================
`default_nettype none

module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int CTRL_W = CPU_CTRL_W,
  parameter int CNT_W  = CPU_CNT_W
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [CTRL_W-1:0] inCtrl,
  input  logic [ADDR_W-1:0] inRs,
  input  logic [ADDR_W-1:0] inRt,
  input  logic              inUsesRs,
  input  logic              inUsesRt,
  input  logic [ADDR_W-1:0] inRd,
  output logic [ADDR_W-1:0] rsAddr,
  output logic [ADDR_W-1:0] rtAddr,
  input  logic [DATA_W-1:0] rsData,
  input  logic [DATA_W-1:0] rtData,
  input  logic              exValid,
  input  logic              exWrEn,
  input  logic              exIsLoad,
  input  logic [ADDR_W-1:0] exRd,
  input  logic              memValid,
  input  logic              memWrEn,
  input  logic [ADDR_W-1:0] memRd,
  input  logic [DATA_W-1:0] memData,
  input  logic              wbWrEn,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0] wbData,
  input  logic              flush,
  output logic              outValid,
  input  logic              outReady,
  output logic [CTRL_W-1:0] outCtrl,
  output logic [ADDR_W-1:0] outRd,
  output logic [DATA_W-1:0] outRsVal,
  output logic [DATA_W-1:0] outRtVal,
  output logic [CNT_W-1:0]  stallCount
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic              r_outValid;
  logic [CTRL_W-1:0] r_outCtrl;
  logic [ADDR_W-1:0] r_outRd;
  logic [DATA_W-1:0] r_outRsVal;
  logic [DATA_W-1:0] r_outRtVal;
  logic [CNT_W-1:0]  r_stallCount;

  logic              w_fwdEn;
  logic              w_exPend;
  logic              w_memPend;
  logic              w_wbPend;
  logic              w_rsHaz;
  logic              w_rtHaz;
  logic              w_hazard;
  logic              w_accept;
  logic [DATA_W-1:0] w_rsVal;
  logic [DATA_W-1:0] w_rtVal;

  // A pending write blocks a source only when its value cannot be forwarded yet.
`ifdef OPFETCH_BYPASS_EN
  assign w_fwdEn   = 1'b1;
  assign w_exPend  = exValid & exWrEn & exIsLoad;
  assign w_memPend = 1'b0;
  assign w_wbPend  = 1'b0;
`else
  logic w_unusedLoad;
  assign w_fwdEn      = 1'b0;
  assign w_exPend     = exValid & exWrEn;
  assign w_memPend    = memValid & memWrEn;
  assign w_wbPend     = wbWrEn;
  assign w_unusedLoad = exIsLoad;
`endif

  assign w_rsHaz = inUsesRs & ((w_exPend  & (exRd   == inRs)) |
                               (w_memPend & (memRd  == inRs)) |
                               (w_wbPend  & (wbAddr == inRs)));
  assign w_rtHaz = inUsesRt & ((w_exPend  & (exRd   == inRt)) |
                               (w_memPend & (memRd  == inRt)) |
                               (w_wbPend  & (wbAddr == inRt)));
  assign w_hazard = w_rsHaz | w_rtHaz;

  assign inReady  = rstN & ~w_hazard & (~r_outValid | outReady);
  assign w_accept = inValid & inReady;

  assign rsAddr = inRs;
  assign rtAddr = inRt;

  fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwdRs (
    .srcAddr  (inRs),
    .fileData (rsData),
    .memValid (memValid & w_fwdEn),
    .memWrEn  (memWrEn),
    .memRd    (memRd),
    .memData  (memData),
    .wbWrEn   (wbWrEn & w_fwdEn),
    .wbAddr   (wbAddr),
    .wbData   (wbData),
    .selData  (w_rsVal)
  );

  fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fwdRt (
    .srcAddr  (inRt),
    .fileData (rtData),
    .memValid (memValid & w_fwdEn),
    .memWrEn  (memWrEn),
    .memRd    (memRd),
    .memData  (memData),
    .wbWrEn   (wbWrEn & w_fwdEn),
    .wbAddr   (wbAddr),
    .wbData   (wbData),
    .selData  (w_rtVal)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_outValid <= 1'b0;
      r_outCtrl  <= '0;
      r_outRd    <= '0;
      r_outRsVal <= '0;
      r_outRtVal <= '0;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_outCtrl  <= inCtrl;
      r_outRd    <= inRd;
      r_outRsVal <= w_rsVal;
      r_outRtVal <= w_rtVal;
    end else if (r_outValid && outReady) begin
      r_outValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_stallCount <= '0;
    end else if (inValid && w_hazard && (r_stallCount != c_CNT_MAX)) begin
      r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign outValid   = r_outValid;
  assign outCtrl    = r_outCtrl;
  assign outRd      = r_outRd;
  assign outRsVal   = r_outRsVal;
  assign outRtVal   = r_outRtVal;
  assign stallCount = r_stallCount;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
// ============================================================================
// Module   : tb_operand_fetch_stage
// Brief    : Directed scenarios plus random traffic against a transaction-level reference model.
//            Expectations follow the OPFETCH_BYPASS_EN setting of the build.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch_stage;
  import cpu_pkg::*;

  localparam int DW = CPU_DATA_W;
  localparam int AW = CPU_ADDR_W;
  localparam int CW = CPU_CTRL_W;
  localparam int NW = CPU_CNT_W;

  logic          clk = 1'b0;
  logic          rstN;
  logic          inValid, inReady, inUsesRs, inUsesRt;
  logic [CW-1:0] inCtrl;
  logic [AW-1:0] inRs, inRt, inRd, rsAddr, rtAddr;
  logic [DW-1:0] rsData, rtData;
  logic          exValid, exWrEn, exIsLoad;
  logic [AW-1:0] exRd;
  logic          memValid, memWrEn;
  logic [AW-1:0] memRd;
  logic [DW-1:0] memData;
  logic          wbWrEn;
  logic [AW-1:0] wbAddr;
  logic [DW-1:0] wbData;
  logic          flush, outValid, outReady;
  logic [CW-1:0] outCtrl;
  logic [AW-1:0] outRd;
  logic [DW-1:0] outRsVal, outRtVal;
  logic [NW-1:0] stallCount;

  always #5 clk = ~clk;

  logic [DW-1:0] regFile [0:(1<<AW)-1];
  assign rsData = regFile[rsAddr];
  assign rtData = regFile[rtAddr];

  operand_fetch_stage dut (
    .clk(clk), .rstN(rstN),
    .inValid(inValid), .inReady(inReady), .inCtrl(inCtrl),
    .inRs(inRs), .inRt(inRt), .inUsesRs(inUsesRs), .inUsesRt(inUsesRt), .inRd(inRd),
    .rsAddr(rsAddr), .rtAddr(rtAddr), .rsData(rsData), .rtData(rtData),
    .exValid(exValid), .exWrEn(exWrEn), .exIsLoad(exIsLoad), .exRd(exRd),
    .memValid(memValid), .memWrEn(memWrEn), .memRd(memRd), .memData(memData),
    .wbWrEn(wbWrEn), .wbAddr(wbAddr), .wbData(wbData),
    .flush(flush), .outValid(outValid), .outReady(outReady),
    .outCtrl(outCtrl), .outRd(outRd), .outRsVal(outRsVal), .outRtVal(outRtVal),
    .stallCount(stallCount)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: the ID/EX slot as a single pending transaction.
  bit            expValid;
  ctrl_t         expCtrl;
  logic [AW-1:0] expRd;
  logic [DW-1:0] expRs, expRt;
  logic [NW-1:0] expStall;
  bit            lastRdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Newest architectural value of register a as seen by the instruction in ID.
  function automatic logic [DW-1:0] operandOf(input logic [AW-1:0] a);
`ifdef OPFETCH_BYPASS_EN
    if (memValid && memWrEn && memRd == a) return memData;
    if (wbWrEn && wbAddr == a) return wbData;
`endif
    return regFile[a];
  endfunction

  // Registers whose pending write cannot be picked up by ID this cycle.
  function automatic bit writePending(input logic [AW-1:0] a);
    logic [AW-1:0] blocked[$];
`ifdef OPFETCH_BYPASS_EN
    if (exValid && exWrEn && exIsLoad) blocked.push_back(exRd);
`else
    if (exValid && exWrEn) blocked.push_back(exRd);
    if (memValid && memWrEn) blocked.push_back(memRd);
    if (wbWrEn) blocked.push_back(wbAddr);
`endif
    foreach (blocked[i]) if (blocked[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mustStall();
    return (inUsesRs && writePending(inRs)) || (inUsesRt && writePending(inRt));
  endfunction

  task automatic clearInputs();
    inValid = 0; inCtrl = '0; inRs = '0; inRt = '0; inUsesRs = 0; inUsesRt = 0; inRd = '0;
    exValid = 0; exWrEn = 0; exIsLoad = 0; exRd = '0;
    memValid = 0; memWrEn = 0; memRd = '0; memData = '0;
    wbWrEn = 0; wbAddr = '0; wbData = '0;
    flush = 0; outReady = 1;
  endtask

  task automatic modelReset();
    expValid = 0; expCtrl = '0; expRd = '0; expRs = '0; expRt = '0; expStall = '0;
  endtask

  // One clock with the currently driven inputs; checks ready before and state after the edge.
  task automatic runCycle();
    bit hz, rdy, acc;
    logic [DW-1:0] nRs, nRt;
    #1;
    hz  = mustStall();
    rdy = !hz && (!expValid || outReady);
    check("inReady", inReady, rdy);
    check("rsAddr", rsAddr, inRs);
    acc = inValid && rdy;
    nRs = operandOf(inRs);
    nRt = operandOf(inRt);
    if (inValid && hz && expStall != '1) expStall = expStall + 1'b1;
    if (flush) expValid = 0;
    else if (acc) begin
      expValid = 1; expCtrl = inCtrl; expRd = inRd; expRs = nRs; expRt = nRt;
    end else if (expValid && outReady) expValid = 0;
    lastRdy = rdy;
    @(posedge clk);
    #1;
    if (wbWrEn) regFile[wbAddr] = wbData;
    check("outValid", outValid, expValid);
    check("stallCount", stallCount, expStall);
    if (expValid) begin
      check("outCtrl", outCtrl, expCtrl);
      check("outRd", outRd, expRd);
      check("outRsVal", outRsVal, expRs);
      check("outRtVal", outRtVal, expRt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW-1:0] stallBase;
    for (int i = 0; i < (1 << AW); i++) regFile[i] = 32'(i) * 32'h111 + 32'h1000;
    regFile[1] = 7; regFile[2] = 2; regFile[3] = 71;
    clearInputs();
    modelReset();
    rstN = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_outValid", outValid, 0);
    check("rst_inReady", inReady, 0);
    check("rst_outRsVal", outRsVal, 0);
    check("rst_outRtVal", outRtVal, 0);
    check("rst_outCtrl", outCtrl, 0);
    check("rst_stall", stallCount, 0);
    @(negedge clk);
    rstN = 1;
    @(posedge clk);
    #1;

    // Back-to-back issue with no hazard.
    for (int i = 0; i < 4; i++) begin
      inValid = 1; inRs = 1; inRt = 2; inUsesRs = 1; inUsesRt = 1;
      inRd = AW'(10 + i); inCtrl = CW'(16'hA000 + i);
      runCycle();
      check("s1_valid", outValid, 1);
      check("s1_rs", outRsVal, 7);
      check("s1_rt", outRtVal, 2);
    end
    inValid = 0;
    runCycle();

    // MEM result wins over WB for the same register.
    inValid = 1; inRs = 1; inRt = 2; inUsesRs = 1; inUsesRt = 1; inRd = 5;
    memValid = 1; memWrEn = 1; memRd = 1; memData = 99;
    wbWrEn = 1; wbAddr = 1; wbData = 55;
    runCycle();
`ifdef OPFETCH_BYPASS_EN
    check("s2_rs", outRsVal, 99);
`else
    check("s2_stall", outValid, 0);
    memValid = 0; memWrEn = 0; wbWrEn = 0;
    runCycle();
    check("s2_rs", outRsVal, 55);
`endif
    clearInputs();
    runCycle();

    // Same-cycle write-back to the register being read.
    inValid = 1; inRt = 3; inUsesRt = 1; inRd = 6;
    wbWrEn = 1; wbAddr = 3; wbData = 5;
    runCycle();
`ifndef OPFETCH_BYPASS_EN
    check("s3_stall", outValid, 0);
    wbWrEn = 0;
    runCycle();
`endif
    check("s3_rt", outRtVal, 5);
    clearInputs();
    runCycle();

    // Load-use: one bubble, then the loaded value arrives via MEM.
    stallBase = expStall;
    inValid = 1; inRs = 2; inUsesRs = 1; inRd = 9;
    exValid = 1; exWrEn = 1; exIsLoad = 1; exRd = 2;
    runCycle();
    check("s4_bubble", outValid, 0);
    check("s4_count", stallCount, stallBase + 1);
    exValid = 0; exWrEn = 0; exIsLoad = 0;
    memValid = 1; memWrEn = 1; memRd = 2; memData = 123;
    runCycle();
`ifndef OPFETCH_BYPASS_EN
    memValid = 0; memWrEn = 0;
    wbWrEn = 1; wbAddr = 2; wbData = 123;
    runCycle();
    wbWrEn = 0;
    runCycle();
`endif
    check("s4_rs", outRsVal, 123);
    clearInputs();
    runCycle();

    // Back-pressure holds the payload; flush discards the slot and the accepted input.
    outReady = 0;
    inValid = 1; inRs = 1; inRt = 2; inUsesRs = 1; inUsesRt = 1; inCtrl = 16'h5A5A; inRd = 7;
    runCycle();
    repeat (3) begin
      runCycle();
      check("s5_ctrl", outCtrl, 16'h5A5A);
      check("s5_valid", outValid, 1);
    end
    outReady = 1; flush = 1; inCtrl = 16'h2222; inRd = 8;
    runCycle();
    check("s5_flush", outValid, 0);
    flush = 0; inValid = 0;
    runCycle();
    check("s5_lost", outValid, 0);

    // Asynchronous reset in the middle of a cycle.
    inValid = 1; inCtrl = 16'h0BAD;
    runCycle();
    check("s6_pre", outValid, 1);
    #3;
    rstN = 0;
    modelReset();
    #1;
    check("s6_valid", outValid, 0);
    check("s6_rs", outRsVal, 0);
    check("s6_ctrl", outCtrl, 0);
    check("s6_ready", inReady, 0);
    check("s6_stall", stallCount, 0);
    @(negedge clk);
    rstN = 1;
    inCtrl = 16'h600D; inRd = 4;
    runCycle();
    check("s6_accept", outValid, 1);
    check("s6_ctrl2", outCtrl, 16'h600D);

    // Random traffic; decode keeps its fields while stalled.
    clearInputs();
    lastRdy = 1;
    repeat (400) begin
      if (!(inValid && !lastRdy)) begin
        inValid  = ($urandom_range(0, 3) != 0);
        inRs     = AW'($urandom_range(0, 3));
        inRt     = AW'($urandom_range(0, 3));
        inUsesRs = 1'($urandom_range(0, 1));
        inUsesRt = 1'($urandom_range(0, 1));
        inRd     = AW'($urandom);
        inCtrl   = CW'($urandom);
      end
      exValid  = 1'($urandom_range(0, 1));
      exWrEn   = 1'($urandom_range(0, 1));
      exIsLoad = ($urandom_range(0, 2) == 0);
      exRd     = AW'($urandom_range(0, 3));
      memValid = 1'($urandom_range(0, 1));
      memWrEn  = 1'($urandom_range(0, 1));
      memRd    = AW'($urandom_range(0, 3));
      memData  = $urandom;
      wbWrEn   = ($urandom_range(0, 2) == 0);
      wbAddr   = AW'($urandom_range(0, 3));
      wbData   = $urandom;
      flush    = ($urandom_range(0, 9) == 0);
      outReady = ($urandom_range(0, 3) != 0);
      runCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
